uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//   Serial receiver: the counterpart of uart_tx. It deserialises 8N1 frames
//   from serial_in, LSB first. Received bytes go into a small show-ahead FIFO
//   that main_bus reads through its UART0 peripheral slot. Frame errors and
//   overruns are reported as one-cycle pulses; the bus side latches them.
//
// PARAMETERS
//   CLK_HZ      12000000  clk frequency in Hz
//   BAUD        115200    line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, >= 4)
//   FIFO_DEPTH  4         receive FIFO entries; power of two, >= 2
//
// PORTS
//   clk            in   1  system clock; all logic is on posedge
//   rst            in   1  synchronous reset, active-low (0 = reset)
//   serial_in      in   1  asynchronous RX line, idle high
//   rx_data        out  8  FIFO head byte; 0 when rx_valid=0
//   rx_valid       out  1  FIFO not empty
//   rx_ready       in   1  pop strobe; pops head when rx_valid & rx_ready
//   rx_frame_err   out  1  1-cycle pulse: stop bit sampled low
//   rx_overrun     out  1  1-cycle pulse: good byte arrived while FIFO full
//   rx_parity_err  out  1  1-cycle pulse: parity mismatch (UART_RX_PARITY_EN)
//
// BEHAVIOUR
//   - Reset (rst=0 at posedge): 2-flop synchroniser = 1, FSM = IDLE, FIFO empty,
//     all pulses 0, rx_valid=0, rx_data=0. A partial frame is discarded.
//   - Sampling: sync = serial_in delayed through 2 flops. Bit counter counts
//     0..CLKS_PER_BIT-1.
//   - IDLE: sync==0 -> START with counter cleared.
//   - START: at count CLKS_PER_BIT/2-1, sample sync.
//     - 1 = glitch -> IDLE.
//     - 0 -> DATA, counter cleared, bit_idx=0.
//   - DATA: sample every CLKS_PER_BIT clocks (mid-bit) and shift right into
//     shreg[7]. After bit_idx 7 -> PARITY if enabled, else STOP.
//   - PARITY: sample one bit. Mismatch sets err_flag; the frame completes
//     normally.
//   - STOP: sample one bit.
//     - 1 and no err_flag -> push shreg, then IDLE.
//     - 1 with err_flag -> rx_parity_err pulse, byte discarded, then IDLE.
//     - 0 -> rx_frame_err pulse, byte discarded, then WAIT_IDLE.
//   - WAIT_IDLE: hold until sync==1, then IDLE. A break never re-triggers START.
//   - Latency: rx_valid/rx_data are updated on the clock after the stop-bit
//     sample edge.
//   - FIFO: wr/rd pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//     empty = ptrs equal; full = MSBs differ, rest equal.
//   - Push while full: byte dropped, FIFO contents unchanged, rx_overrun pulses.
//   - Pop and push in the same cycle:
//     - FIFO full: pop applies first, push accepted, no overrun.
//     - FIFO empty: pop ignored (rx_valid=0), push accepted.
//   - rx_ready while rx_valid=0: no effect.
//   - Error pulses are mutually exclusive and last exactly one clock.
//
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Frame is 8E1: even parity bit between data and stop.
//     - A frame with even total ones across data+parity is accepted.
//   UART_RX_PARITY_EN undefined:
//     - Frame is 8N1; the PARITY state is not built.
//     - rx_parity_err is tied 0.
//
// TESTING  (CLK_HZ=1152000, BAUD=115200 -> 10 clks/bit, FIFO_DEPTH=4)
//   1. Reset, then send 0x55 8N1 -> rx_valid=1, rx_data=0x55 one clock after
//      stop sample. Pulse rx_ready -> rx_valid=0, rx_data=0.
//   2. Low glitch of 3 clks on idle line -> FSM returns to IDLE, no push,
//      no error pulse.
//   3. Send 0xA3 with stop bit held low for 2 bit times -> one rx_frame_err
//      pulse, no byte. Then send 0x0F -> rx_data=0x0F.
//   4. Send 0x01..0x05 without popping -> FIFO holds 01..04, one rx_overrun
//      on byte 05. Pops return 01,02,03,04 in order.
//   5. FIFO full; pop in the exact cycle a new byte 0x77 is pushed -> no
//      overrun, and 0x77 is read last.
//   6. Assert rst=0 mid-DATA of 0xC3 -> FIFO empty, no pulses. With
//      UART_RX_PARITY_EN, 0x07 with parity=0 -> rx_parity_err pulse, no byte.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) feeding a show-ahead FIFO.
// Error and overrun conditions are reported as single-cycle pulses.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_parity_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
    } state_t;
`endif

    state_t          r_state, w_next;
    logic            r_sync1, r_sync2;
    logic            w_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shreg;
    logic            w_tick_half, w_tick_full;
    logic            w_cnt_clr, w_shift, w_push, w_frame_err, w_parity_err;
    logic            w_err_flag;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic            w_empty, w_full, w_pop, w_wr_en, w_overrun;
    logic            r_frame_err, r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sync      = r_sync2;
    assign w_tick_half = (r_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign w_tick_full = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (!w_sync) w_next = S_START;
            S_START:     if (w_tick_half) w_next = w_sync ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:      if (w_tick_full && r_bit_idx == 3'd7) w_next = S_PARITY;
            S_PARITY:    if (w_tick_full) w_next = S_STOP;
`else
            S_DATA:      if (w_tick_full && r_bit_idx == 3'd7) w_next = S_STOP;
`endif
            S_STOP:      if (w_tick_full) w_next = w_sync ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_sync) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic w_par_sample;
    logic r_err_flag;
`endif

    always_comb begin
        w_cnt_clr    = 1'b0;
        w_shift      = 1'b0;
        w_push       = 1'b0;
        w_frame_err  = 1'b0;
        w_parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        unique case (r_state)
            S_IDLE:      w_cnt_clr = 1'b1;
            S_START:     w_cnt_clr = w_tick_half;
            S_DATA: begin
                w_cnt_clr = w_tick_full;
                w_shift   = w_tick_full;
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                w_cnt_clr    = w_tick_full;
                w_par_sample = w_tick_full;
            end
`endif
            S_STOP: begin
                w_cnt_clr = w_tick_full;
                if (w_tick_full) begin
                    if (!w_sync)        w_frame_err  = 1'b1;
                    else if (w_err_flag) w_parity_err = 1'b1;
                    else                w_push       = 1'b1;
                end
            end
            S_WAIT_IDLE: w_cnt_clr = 1'b1;
            default:     w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == S_START) r_bit_idx <= '0;
            else if (w_shift)       r_bit_idx <= r_bit_idx + 1'b1;
            if (w_shift) r_shreg <= {w_sync, r_shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits.
    always_ff @(posedge clk) begin
        if (!rst)                    r_err_flag <= 1'b0;
        else if (r_state == S_IDLE)  r_err_flag <= 1'b0;
        else if (w_par_sample)       r_err_flag <= (w_sync != ^r_shreg);
    end
    assign w_err_flag = r_err_flag;
`else
    assign w_err_flag = 1'b0;
`endif

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = rx_ready && !w_empty;
    // A simultaneous pop frees the head slot, so a push into a full FIFO is still accepted.
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_overrun = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_shreg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_err;
            r_overrun   <= w_overrun;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;
    always_ff @(posedge clk) begin
        if (!rst) r_parity_err <= 1'b0;
        else      r_parity_err <= w_parity_err;
    end
    assign rx_parity_err = r_parity_err;
`else
    logic w_unused;
    assign w_unused      = w_parity_err;
    assign rx_parity_err = 1'b0;
`endif

    assign rx_valid     = !w_empty;
    assign rx_data      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign rx_frame_err = r_frame_err;
    assign rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 clocks per bit, 4-entry FIFO.
// Inputs change and outputs are checked on falling edges.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_overrun, rx_parity_err;

    int checks = 0, failures = 0;
    int n_fe = 0, n_ovr = 0, n_pe = 0;

    uart_rx #(.CLK_HZ(1152000), .BAUD(115200), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun),
        .rx_parity_err(rx_parity_err)
    );

    always #5 clk = ~clk;

    // Count how many clock cycles each pulse output spends high.
    always @(posedge clk) begin
        n_fe  = n_fe  + int'(rx_frame_err);
        n_ovr = n_ovr + int'(rx_overrun);
        n_pe  = n_pe  + int'(rx_parity_err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d);
        drive_bit(1'b1);
    endtask

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] exp5 [4];
        exp5[0] = 8'h22; exp5[1] = 8'h33; exp5[2] = 8'h44; exp5[3] = 8'h77;

        repeat (3) @(negedge clk);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_fe", rx_frame_err, 0);
        check("reset_ovr", rx_overrun, 0);
        check("reset_pe", rx_parity_err, 0);
        rst = 1'b1;
        idle(20);

        // 1: 0x55, rx_valid exactly one clock after the stop sample
        send_head(8'h55);
        serial_in = 1'b1;
        repeat (7) @(negedge clk);
        check("t1_valid_before", rx_valid, 0);
        @(negedge clk);
        check("t1_valid_after", rx_valid, 1);
        check("t1_data", rx_data, 8'h55);
        repeat (2) @(negedge clk);
        pop();
        check("t1_valid_popped", rx_valid, 0);
        check("t1_data_popped", rx_data, 0);

        // 2: 3-clock low glitch
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        idle(30);
        check("t2_valid", rx_valid, 0);
        check("t2_fe", n_fe, 0);
        check("t2_ovr", n_ovr, 0);

        // 3: 0xA3 with stop held low for two bit times, then 0x0F
        send_head(8'hA3);
        serial_in = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        idle(20);
        check("t3_fe_count", n_fe, 1);
        check("t3_valid", rx_valid, 0);
        check("t3_pe", n_pe, 0);
        send_frame(8'h0F);
        idle(5);
        check("t3_valid2", rx_valid, 1);
        check("t3_data2", rx_data, 8'h0F);
        pop();
        check("t3_empty", rx_valid, 0);

        // 4: 0x01..0x05 without popping
        for (int b = 1; b <= 5; b++) send_frame(8'(b));
        idle(5);
        check("t4_ovr_count", n_ovr, 1);
        check("t4_fe", n_fe, 1);
        for (int b = 1; b <= 4; b++) begin
            check("t4_valid", rx_valid, 1);
            check("t4_data", rx_data, b);
            pop();
        end
        check("t4_empty", rx_valid, 0);

        // 5: full FIFO, pop exactly at the push edge of 0x77
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        send_frame(8'h44);
        send_head(8'h77);
        serial_in = 1'b1;
        repeat (7) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_ovr", n_ovr, 1);
        for (int i = 0; i < 4; i++) begin
            check("t5_valid", rx_valid, 1);
            check("t5_data", rx_data, exp5[i]);
            pop();
        end
        check("t5_empty", rx_valid, 0);

        // 6: reset in the middle of 0xC3 data bits, with a byte already queued
        send_frame(8'h5A);
        idle(2);
        check("t6_pre_data", rx_data, 8'h5A);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b0;
        serial_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(20);
        check("t6_valid", rx_valid, 0);
        check("t6_data", rx_data, 0);
        check("t6_fe", n_fe, 1);
        check("t6_ovr", n_ovr, 1);
        send_frame(8'h3C);
        idle(5);
        check("t6_after_data", rx_data, 8'h3C);
        pop();

`ifdef UART_RX_PARITY_EN
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3 ? 1'b1 : 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(5);
        check("t6_pe_count", n_pe, 1);
        check("t6_pe_valid", rx_valid, 0);
        check("t6_pe_fe", n_fe, 1);
`else
        check("t6_pe_tied", n_pe, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
